varint_writer: RTL and testbench
================================

# varint_writer

Parametrised varint serialization engine for the protobuf serializer datapath. It accepts one scalar field value per handshake and applies zigzag and 32-bit masking according to the protobuf field type. It encodes the value as a 1–10 byte varint and writes the bytes backwards into DRAM through a LANES-wide byte-lane write port, ending at `dst_addr`. It generalises the fixed 8-lane, two-phase varint writer: configurable lane count and DRAM wait, multi-beat sequencing, valid/ready input handshake, and correct encoding of value 0.

## Interface
- LANES, 8, bytes per DRAM write beat; legal values 1, 2, 4, 8, 16.
- WAIT_CYCLES, 21, idle cycles after each write beat before the next beat or completion; must be ≥1.
- ADDR_W, 64, DRAM address width.

Ports:
- clk  in  1  single clock; all logic on posedge.
- reset  in  1  synchronous, active-low; 0 = reset.
- in_valid  in  1  request valid.
- in_ready  out  1  high only in IDLE.
- value  in  64  raw field value.
- field_type  in  5  protobuf type code.
- dst_addr  in  ADDR_W  address of the last (highest-address) varint byte.
- dram_en  out  LANES  per-lane write enable.
- dram_addr  out  LANES×ADDR_W  per-lane byte address.
- dram_data  out  LANES×8  per-lane byte.
- dram_rdwr  out  1  constant 0 (write).
- done  out  1  one-cycle completion pulse.
- bytes_written  out  4  varint length n (1–10); held until the next accept.

## Operation
- Accept when in_valid & in_ready.
  - Register value, field_type, dst_addr.
  - in_valid is ignored outside IDLE.
- Zigzag is applied for field_type 17 (sint32) and 18 (sint64).
- 32-bit types are 0, 2, 5, 7, 13, 15, 17.
  - For non-zigzag 32-bit types, the encoder input is value[31:0] zero-extended.
  - For sint32, zigzag is applied over 32 bits.
- Encoding: 7-bit groups b0 (LSB group) … b(n-1).
  - Bit 7 is set on all bytes except b(n-1).
  - n = max(1, ceil(msb_index+1 / 7)); value 0 gives n=1, byte 0x00.
- Placement: b(n-1-i) is written to dst_addr − i.
- Beat k, lane j carries index i = k·LANES + j, enabled iff i < n.
  - Beats = ceil(n/LANES).
  - Disabled lanes drive addr/data 0.
- Address arithmetic is modulo 2^ADDR_W; wrap below 0 is permitted, with no error.
- FSM states:
  - IDLE → ENCODE on accept.
  - ENCODE → WRITE: latch the encoded bytes and n.
  - WRITE → WAIT: dram_en is nonzero for exactly this cycle.
  - WAIT: counter runs 1..WAIT_CYCLES.
    - At WAIT_CYCLES, go to WRITE if beats remain, else to DONE.
  - DONE → IDLE: done=1 in this state.
- bytes_written is updated to n in ENCODE.

## Timing
- Reset values: in_ready=0 during reset, 1 on the first cycle after reset. dram_en=0, dram_addr=0, dram_data=0, dram_rdwr=0, done=0, bytes_written=0. State returns to IDLE and the counter is cleared.
- All outputs are registered.
- With the accept edge at cycle 0:
  - ENCODE in cycle 1.
  - First WRITE in cycle 2.
  - Beat k WRITE in cycle 2 + k·(WAIT_CYCLES+1).
  - done in cycle 2 + B·(WAIT_CYCLES+1), where B is the beat count.
  - IDLE (in_ready=1) in the following cycle.
- Back-to-back throughput: one accept per 3 + B·(WAIT_CYCLES+1) cycles.
- Reset asserted mid-operation aborts immediately. Beats not yet issued are never written.
- done and in_ready are never high in the same cycle.

## Structure
- Package `varint_pkg` holds:
  - field-type constants;
  - `is_zigzag` / `is_32bit` decode functions;
  - the FSM state enum;
  - MAX_VARINT_BYTES = 10.
- Sub-module `varint_encode_core` (combinational) contains zigzag, masking, the 10-byte encode, and the length count. The top level holds the FSM, counter, and lane mapping.

## Test plan
- LANES=8, W=21: value 300, type 4, dst 0x1000.
  - Cycle 2: dram_en=0x03; lane0 0x1000/0x02, lane1 0x0FFF/0xAC.
  - done at cycle 24, bytes_written=2.
- value 0, type 13 → one beat; lane0 data 0x00 at dst_addr; bytes_written=1.
- value −1, type 3, LANES=8, dst 0x2000 → two beats.
  - Beat0: en=0xFF; lane0 0x01 at 0x2000, lanes1–7 0xFF.
  - Beat1 (cycle 24): en=0x03, 0xFF at 0x1FF8 and 0x1FF7.
  - done at cycle 46, bytes_written=10.
- value 0xFFFF_FFFF_FFFF_FFFF, type 5 → 5 bytes FF FF FF FF 0F; 0x0F at dst_addr. Type 17 with the same value → zigzag 1 → single byte 0x01.
- LANES=1, W=1, value 300, dst 0x0 → 0x02 at 0x0, then 0xAC at 0xFFFF_FFFF_FFFF_FFFF (wrap); done at cycle 6.
- Reset low at cycle 3 of a two-beat job → all outputs 0 the next cycle; no beat1 enables; in_ready=1 after reset releases. in_valid held high during busy states → no extra accepts.

Source files
------------

// File: rtl/varint_pkg.sv
// Shared definitions for the varint serialization engine.
// Holds the protobuf field-type codes that affect encoding, the type decode
// helpers, the writer FSM state type and the maximum varint length.
package varint_pkg;

    localparam int MAX_VARINT_BYTES = 10;

    localparam logic [4:0] FT_TYPE0    = 5'd0;
    localparam logic [4:0] FT_FLOAT    = 5'd2;
    localparam logic [4:0] FT_INT64    = 5'd3;
    localparam logic [4:0] FT_UINT64   = 5'd4;
    localparam logic [4:0] FT_INT32    = 5'd5;
    localparam logic [4:0] FT_FIXED32  = 5'd7;
    localparam logic [4:0] FT_UINT32   = 5'd13;
    localparam logic [4:0] FT_SFIXED32 = 5'd15;
    localparam logic [4:0] FT_SINT32   = 5'd17;
    localparam logic [4:0] FT_SINT64   = 5'd18;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ENCODE,
        ST_WRITE,
        ST_WAIT,
        ST_DONE
    } state_t;

    function automatic logic is_zigzag(input logic [4:0] field_type);
        return (field_type == FT_SINT32) || (field_type == FT_SINT64);
    endfunction

    function automatic logic is_32bit(input logic [4:0] field_type);
        return (field_type == FT_TYPE0)   || (field_type == FT_FLOAT)    ||
               (field_type == FT_INT32)   || (field_type == FT_FIXED32)  ||
               (field_type == FT_UINT32)  || (field_type == FT_SFIXED32) ||
               (field_type == FT_SINT32);
    endfunction

endpackage

// File: rtl/varint_writer_encode_core.sv
// Combinational varint encoder.
// Ports:
//   value      - raw 64-bit field value
//   field_type - protobuf type code (selects zigzag and 32-bit masking)
//   enc_bytes  - encoded bytes, enc_bytes[0] is the least significant group
//   enc_len    - number of valid bytes, 1..10
module varint_encode_core
    import varint_pkg::*;
(
    input  logic [63:0]                             value,
    input  logic [4:0]                              field_type,
    output logic [MAX_VARINT_BYTES-1:0][7:0]        enc_bytes,
    output logic [3:0]                              enc_len
);

    logic [63:0] mapped;
    logic [69:0] padded;

    always_comb begin
        mapped = value;
        if (is_zigzag(field_type) && is_32bit(field_type)) begin
            mapped = {32'd0, (value[31:0] << 1) ^ {32{value[31]}}};
        end else if (is_zigzag(field_type)) begin
            mapped = (value << 1) ^ {64{value[63]}};
        end else if (is_32bit(field_type)) begin
            mapped = {32'd0, value[31:0]};
        end
    end

    // Padded to 10 full groups so the top group slices cleanly; zero always
    // yields length 1 because the search starts at one byte.
    always_comb begin
        padded  = {6'd0, mapped};
        enc_len = 4'd1;
        for (int g = 1; g < MAX_VARINT_BYTES; g++) begin
            if ((padded >> (7 * g)) != '0) begin
                enc_len = 4'(g + 1);
            end
        end
        for (int g = 0; g < MAX_VARINT_BYTES; g++) begin
            enc_bytes[g][6:0] = padded[7*g +: 7];
            enc_bytes[g][7]   = (4'(g) + 4'd1) < enc_len;
        end
    end

endmodule

// File: rtl/varint_writer.sv
// Varint writer: accepts one field value per handshake, encodes it and
// writes the bytes backwards into DRAM so the last byte lands at dst_addr.
// Ports:
//   clk, reset           - clock, synchronous active-low reset
//   in_valid/in_ready    - request handshake (ready only while idle)
//   value/field_type     - field to encode
//   dst_addr             - address of the highest-address varint byte
//   dram_en/addr/data    - LANES-wide byte-lane write port
//   dram_rdwr            - always write (0)
//   done                 - one-cycle completion pulse
//   bytes_written        - varint length of the current/last job
//
// state     | meaning
// ST_IDLE   | ready for a request
// ST_ENCODE | encoder settles on registered inputs; first beat prepared
// ST_WRITE  | one write beat on the DRAM port
// ST_WAIT   | WAIT_CYCLES idle cycles after each beat
// ST_DONE   | done pulse, then back to idle
module varint_writer
    import varint_pkg::*;
#(
    parameter int LANES       = 8,
    parameter int WAIT_CYCLES = 21,
    parameter int ADDR_W      = 64
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [63:0]               value,
    input  logic [4:0]                field_type,
    input  logic [ADDR_W-1:0]         dst_addr,
    output logic [LANES-1:0]          dram_en,
    output logic [LANES*ADDR_W-1:0]   dram_addr,
    output logic [LANES*8-1:0]        dram_data,
    output logic                      dram_rdwr,
    output logic                      done,
    output logic [3:0]                bytes_written
);

    localparam int CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;

    state_t                              state;
    logic [63:0]                         value_q;
    logic [4:0]                          type_q;
    logic [ADDR_W-1:0]                   dst_q;
    logic [MAX_VARINT_BYTES-1:0][7:0]    bytes_q;
    logic [3:0]                          len_q;
    logic [7:0]                          base_q;
    logic [CNT_W-1:0]                    cnt;

    logic [MAX_VARINT_BYTES-1:0][7:0]    enc_bytes;
    logic [3:0]                          enc_len;

    logic [MAX_VARINT_BYTES-1:0][7:0]    src_bytes;
    logic [3:0]                          src_len;
    logic [7:0]                          src_base;
    logic [7:0]                          idx;
    logic [3:0]                          pos;
    logic [LANES-1:0]                    lane_en;
    logic [LANES*ADDR_W-1:0]             lane_addr;
    logic [LANES*8-1:0]                  lane_data;

    varint_encode_core u_core (
        .value      (value_q),
        .field_type (type_q),
        .enc_bytes  (enc_bytes),
        .enc_len    (enc_len)
    );

    assign dram_rdwr = 1'b0;

    // Lane mapping for the beat about to be registered. The first beat is
    // built straight from the encoder so it can issue the cycle after ENCODE.
    always_comb begin
        src_bytes = (state == ST_ENCODE) ? enc_bytes : bytes_q;
        src_len   = (state == ST_ENCODE) ? enc_len   : len_q;
        src_base  = (state == ST_ENCODE) ? 8'd0      : base_q;
        lane_en   = '0;
        lane_addr = '0;
        lane_data = '0;
        idx       = '0;
        pos       = '0;
        for (int j = 0; j < LANES; j++) begin
            idx = src_base + 8'(j);
            pos = src_len - 4'(idx) - 4'd1;
            if (idx < {4'd0, src_len}) begin
                lane_en[j]                     = 1'b1;
                lane_addr[j*ADDR_W +: ADDR_W]  = dst_q - ADDR_W'(idx);
                lane_data[j*8 +: 8]            = src_bytes[pos];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state         <= ST_IDLE;
            in_ready      <= 1'b0;
            value_q       <= '0;
            type_q        <= '0;
            dst_q         <= '0;
            bytes_q       <= '0;
            len_q         <= '0;
            base_q        <= '0;
            cnt           <= '0;
            dram_en       <= '0;
            dram_addr     <= '0;
            dram_data     <= '0;
            done          <= 1'b0;
            bytes_written <= '0;
        end else begin
            dram_en   <= '0;
            dram_addr <= '0;
            dram_data <= '0;
            done      <= 1'b0;
            case (state)
                ST_IDLE: begin
                    in_ready <= 1'b1;
                    if (in_valid && in_ready) begin
                        value_q  <= value;
                        type_q   <= field_type;
                        dst_q    <= dst_addr;
                        in_ready <= 1'b0;
                        state    <= ST_ENCODE;
                    end
                end
                ST_ENCODE: begin
                    bytes_q       <= enc_bytes;
                    len_q         <= enc_len;
                    bytes_written <= enc_len;
                    dram_en       <= lane_en;
                    dram_addr     <= lane_addr;
                    dram_data     <= lane_data;
                    base_q        <= 8'(LANES);
                    state         <= ST_WRITE;
                end
                ST_WRITE: begin
                    cnt   <= CNT_W'(WAIT_CYCLES - 1);
                    state <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (cnt == '0) begin
                        if (base_q < {4'd0, len_q}) begin
                            dram_en   <= lane_en;
                            dram_addr <= lane_addr;
                            dram_data <= lane_data;
                            base_q    <= base_q + 8'(LANES);
                            state     <= ST_WRITE;
                        end else begin
                            done  <= 1'b1;
                            state <= ST_DONE;
                        end
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                ST_DONE: begin
                    in_ready <= 1'b1;
                    state    <= ST_IDLE;
                end
                default: begin
                    in_ready <= 1'b0;
                    state    <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_varint_writer.sv
module tb_varint_writer;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         valid8 = 1'b0;
    logic         valid1 = 1'b0;
    logic [63:0]  value = '0;
    logic [4:0]   field_type = '0;
    logic [63:0]  dst_addr = '0;

    logic         ready8, rdwr8, done8;
    logic [7:0]   en8;
    logic [511:0] addr8;
    logic [63:0]  data8;
    logic [3:0]   bw8;

    logic         ready1, rdwr1, done1;
    logic [0:0]   en1;
    logic [63:0]  addr1;
    logic [7:0]   data1;
    logic [3:0]   bw1;

    varint_writer #(.LANES(8), .WAIT_CYCLES(21), .ADDR_W(64)) dut8 (
        .clk(clk), .reset(reset), .in_valid(valid8), .in_ready(ready8),
        .value(value), .field_type(field_type), .dst_addr(dst_addr),
        .dram_en(en8), .dram_addr(addr8), .dram_data(data8), .dram_rdwr(rdwr8),
        .done(done8), .bytes_written(bw8)
    );

    varint_writer #(.LANES(1), .WAIT_CYCLES(1), .ADDR_W(64)) dut1 (
        .clk(clk), .reset(reset), .in_valid(valid1), .in_ready(ready1),
        .value(value), .field_type(field_type), .dst_addr(dst_addr),
        .dram_en(en1), .dram_addr(addr1), .dram_data(data1), .dram_rdwr(rdwr1),
        .done(done1), .bytes_written(bw1)
    );

    always #5 clk = ~clk;

    bit            cur_sel = 1'b0;
    logic [15:0]   obs_en;
    logic [1023:0] obs_addr;
    logic [127:0]  obs_data;
    logic          obs_ready, obs_done, obs_rdwr;
    logic [3:0]    obs_bw;

    always_comb begin
        obs_en    = cur_sel ? {15'd0, en1}    : {8'd0, en8};
        obs_addr  = cur_sel ? {960'd0, addr1} : {512'd0, addr8};
        obs_data  = cur_sel ? {120'd0, data1} : {64'd0, data8};
        obs_ready = cur_sel ? ready1 : ready8;
        obs_done  = cur_sel ? done1  : done8;
        obs_rdwr  = cur_sel ? rdwr1  : rdwr8;
        obs_bw    = cur_sel ? bw1    : bw8;
    end

    int          n_total = 0;
    int          n_bad = 0;
    int          prev_n [2];
    logic [7:0]  ref_bytes [10];
    int          ref_n;
    logic [15:0] cap_en;
    logic [7:0]  cap_d0;

    // Reference: protobuf rules with plain arithmetic; ref_bytes[0] is the
    // low-order group, emitted by repeated divide-by-128.
    function automatic void ref_encode(input logic [63:0] v, input logic [4:0] ft);
        longint      s;
        logic [63:0] u;
        if (ft == 5'd17) begin
            s = longint'(int'(v[31:0]));
            u = (s >= 0) ? 64'(2 * s) : 64'(-2 * s - 1);
            u = u & 64'h0000_0000_FFFF_FFFF;
        end else if (ft == 5'd18) begin
            s = longint'(v);
            u = (s >= 0) ? 64'(2 * s) : 64'(-2 * s - 1);
        end else if (ft == 5'd0 || ft == 5'd2 || ft == 5'd5 || ft == 5'd7 ||
                     ft == 5'd13 || ft == 5'd15) begin
            u = {32'd0, v[31:0]};
        end else begin
            u = v;
        end
        ref_n = 0;
        do begin
            ref_bytes[ref_n] = 8'(u % 64'd128);
            u = u / 64'd128;
            if (u != 0) ref_bytes[ref_n][7] = 1'b1;
            ref_n++;
        end while (u != 0);
    endfunction

    task automatic run_job(input bit sel, input logic [63:0] v, input logic [4:0] ft,
                           input logic [63:0] dst, input bit hold);
        int L, W, B, done_c, waited, k, i, n;
        logic [15:0]   exp_en;
        logic [1023:0] exp_addr;
        logic [127:0]  exp_data;
        logic [3:0]    exp_bw;
        cur_sel = sel;
        L = sel ? 1 : 8;
        W = sel ? 1 : 21;
        ref_encode(v, ft);
        n = ref_n;
        B = (n + L - 1) / L;
        done_c = 2 + B * (W + 1);
        value = v;
        field_type = ft;
        dst_addr = dst;
        if (sel) valid1 = 1'b1; else valid8 = 1'b1;
        waited = 0;
        #1;
        while (!obs_ready && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        if (!obs_ready) begin
            n_total++;
            n_bad++;
            $display("FAIL accept_wait sel=%0d in_ready got=0 exp=1", sel);
            valid1 = 1'b0;
            valid8 = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        if (!hold) begin
            valid1 = 1'b0;
            valid8 = 1'b0;
        end
        value = {$urandom(), $urandom()};
        field_type = 5'($urandom_range(0, 31));
        dst_addr = {$urandom(), $urandom()};
        for (int c = 1; c <= done_c + 1; c++) begin
            @(negedge clk);
            exp_en = '0;
            exp_addr = '0;
            exp_data = '0;
            if (c >= 2 && ((c - 2) % (W + 1)) == 0) begin
                k = (c - 2) / (W + 1);
                if (k < B) begin
                    for (int j = 0; j < L; j++) begin
                        i = k * L + j;
                        if (i < n) begin
                            exp_en[j] = 1'b1;
                            exp_addr[j*64 +: 64] = dst - 64'(i);
                            exp_data[j*8 +: 8] = ref_bytes[n - 1 - i];
                        end
                    end
                end
            end
            exp_bw = (c >= 2) ? 4'(n) : 4'(prev_n[sel]);
            n_total += 7;
            if (obs_en !== exp_en) begin
                n_bad++;
                $display("FAIL dram_en sel=%0d c=%0d got=%h exp=%h", sel, c, obs_en, exp_en);
            end
            if (obs_addr !== exp_addr) begin
                n_bad++;
                $display("FAIL dram_addr sel=%0d c=%0d got=%h exp=%h", sel, c,
                         obs_addr[511:0], exp_addr[511:0]);
            end
            if (obs_data !== exp_data) begin
                n_bad++;
                $display("FAIL dram_data sel=%0d c=%0d got=%h exp=%h", sel, c, obs_data, exp_data);
            end
            if (obs_done !== (c == done_c)) begin
                n_bad++;
                $display("FAIL done sel=%0d c=%0d got=%b exp=%b", sel, c, obs_done, c == done_c);
            end
            if (obs_ready !== (c == done_c + 1)) begin
                n_bad++;
                $display("FAIL in_ready sel=%0d c=%0d got=%b exp=%b", sel, c, obs_ready,
                         c == done_c + 1);
            end
            if (obs_bw !== exp_bw) begin
                n_bad++;
                $display("FAIL bytes_written sel=%0d c=%0d got=%0d exp=%0d", sel, c, obs_bw, exp_bw);
            end
            if (obs_rdwr !== 1'b0) begin
                n_bad++;
                $display("FAIL dram_rdwr sel=%0d c=%0d got=%b exp=0", sel, c, obs_rdwr);
            end
            if (c == 2) begin
                cap_en = obs_en;
                cap_d0 = obs_data[7:0];
            end
        end
        prev_n[sel] = n;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (3) @(negedge clk);
        n_total += 2;
        if ({ready8, en8, addr8, data8, rdwr8, done8, bw8} !== '0) begin
            n_bad++;
            $display("FAIL reset_outputs8 got=%b/%h/%h exp=all zero", ready8, en8, bw8);
        end
        if ({ready1, en1, addr1, data1, rdwr1, done1, bw1} !== '0) begin
            n_bad++;
            $display("FAIL reset_outputs1 got=%b/%h/%h exp=all zero", ready1, en1, bw1);
        end
        reset = 1'b1;
        @(negedge clk);
        n_total += 2;
        if (ready8 !== 1'b1) begin
            n_bad++;
            $display("FAIL ready_after_reset8 got=%b exp=1", ready8);
        end
        if (ready1 !== 1'b1) begin
            n_bad++;
            $display("FAIL ready_after_reset1 got=%b exp=1", ready1);
        end
        prev_n[0] = 0;
        prev_n[1] = 0;
    endtask

    task automatic test_directed();
        run_job(1'b0, 64'd300, 5'd4, 64'h1000, 1'b0);
        n_total += 3;
        if (cap_en !== 16'h0003) begin
            n_bad++;
            $display("FAIL dir300_en got=%h exp=0003", cap_en);
        end
        if (cap_d0 !== 8'h02) begin
            n_bad++;
            $display("FAIL dir300_lane0 got=%h exp=02", cap_d0);
        end
        if (bw8 !== 4'd2) begin
            n_bad++;
            $display("FAIL dir300_len got=%0d exp=2", bw8);
        end
        run_job(1'b0, 64'd0, 5'd13, 64'h1234, 1'b0);
        n_total++;
        if (bw8 !== 4'd1) begin
            n_bad++;
            $display("FAIL dir_zero_len got=%0d exp=1", bw8);
        end
        run_job(1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 5'd3, 64'h2000, 1'b0);
        n_total += 2;
        if (bw8 !== 4'd10) begin
            n_bad++;
            $display("FAIL dir_neg1_len got=%0d exp=10", bw8);
        end
        if (cap_d0 !== 8'h01) begin
            n_bad++;
            $display("FAIL dir_neg1_lane0 got=%h exp=01", cap_d0);
        end
        run_job(1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 5'd5, 64'h3000, 1'b0);
        n_total += 2;
        if (bw8 !== 4'd5 || cap_d0 !== 8'h0F) begin
            n_bad += 1;
            $display("FAIL dir_int32_ones got=%0d/%h exp=5/0f", bw8, cap_d0);
        end
        if (cap_en !== 16'h001F) begin
            n_bad++;
            $display("FAIL dir_int32_en got=%h exp=001f", cap_en);
        end
        run_job(1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 5'd17, 64'h3000, 1'b0);
        n_total++;
        if (bw8 !== 4'd1 || cap_d0 !== 8'h01) begin
            n_bad++;
            $display("FAIL dir_sint32 got=%0d/%h exp=1/01", bw8, cap_d0);
        end
        run_job(1'b1, 64'd300, 5'd4, 64'h0, 1'b0);
        n_total++;
        if (bw1 !== 4'd2 || cap_d0 !== 8'h02) begin
            n_bad++;
            $display("FAIL dir_lanes1 got=%0d/%h exp=2/02", bw1, cap_d0);
        end
    endtask

    task automatic test_random(input bit sel, input int count);
        logic [63:0] v, d;
        for (int t = 0; t < count; t++) begin
            v = {$urandom(), $urandom()} >> $urandom_range(0, 63);
            if ($urandom_range(0, 7) == 0) v = '0;
            d = {$urandom(), $urandom()};
            if ($urandom_range(0, 3) == 0) d = 64'($urandom_range(0, 12));
            run_job(sel, v, 5'($urandom_range(0, 18)), d, 1'b0);
        end
    endtask

    task automatic test_back_to_back(input bit sel, input int count);
        for (int t = 0; t < count; t++) begin
            run_job(sel, {$urandom(), $urandom()} >> $urandom_range(0, 63),
                    5'($urandom_range(0, 18)), {$urandom(), $urandom()}, 1'b1);
        end
        valid8 = 1'b0;
        valid1 = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset_midjob();
        int seen;
        cur_sel = 1'b0;
        value = 64'hFFFF_FFFF_FFFF_FFFF;
        field_type = 5'd3;
        dst_addr = 64'h2000;
        valid8 = 1'b1;
        @(posedge clk);
        #1;
        valid8 = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        n_total++;
        if ({ready8, en8, addr8, data8, rdwr8, done8, bw8} !== '0) begin
            n_bad++;
            $display("FAIL midjob_reset_outputs got=%b/%h/%b/%h exp=all zero", ready8, en8, done8, bw8);
        end
        reset = 1'b1;
        @(negedge clk);
        n_total++;
        if (ready8 !== 1'b1) begin
            n_bad++;
            $display("FAIL midjob_ready_after got=%b exp=1", ready8);
        end
        seen = 0;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            if (en8 !== 8'h00 || done8 !== 1'b0) seen++;
        end
        n_total++;
        if (seen != 0) begin
            n_bad++;
            $display("FAIL midjob_no_beat1 got=%0d active cycles exp=0", seen);
        end
        prev_n[0] = 0;
        prev_n[1] = 0;
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        prev_n[0] = 0;
        prev_n[1] = 0;
        test_reset();
        test_directed();
        test_random(1'b0, 20);
        test_random(1'b1, 15);
        test_back_to_back(1'b0, 4);
        test_back_to_back(1'b1, 4);
        test_reset_midjob();
        test_random(1'b0, 3);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
